// File: rtl/uart_pkg.sv
// Shared encodings and types for the UART transmit path.
package uart_pkg;

    localparam logic [1:0] MODE_SYNC    = 2'b00;
    localparam logic [1:0] MODE_ASYNC8  = 2'b01;
    localparam logic [1:0] MODE_ASYNC9A = 2'b10;
    localparam logic [1:0] MODE_ASYNC9B = 2'b11;

    localparam logic [7:0] DEFAULT_TX_ADDR = 8'h99;

    typedef enum logic [2:0] {IDLE, START, DATA, NINTH, STOP} tx_state_e;

    // Frame format captured when a byte leaves the FIFO.
    typedef struct packed {
        logic [1:0] mode;
        logic       par_en;
        logic       par_odd;
        logic       tb8;
        logic       stop2;
    } tx_cfg_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == LVL_W'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// 8051-style serial transmitter with a TX FIFO: mode-0 sync shift or framed async output,
// paced by an external baud tick with OSR ticks per bit.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OSR        = 16,
    parameter logic [7:0]  TX_ADDR    = DEFAULT_TX_ADDR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     ab,
    input  logic                           wrn,
    input  logic [7:0]                     db_w,
    input  logic                           baud_tick,
    input  logic [1:0]                     mode,
    input  logic                           par_en,
    input  logic                           par_odd,
    input  logic                           tb8,
    input  logic                           stop2,
    output logic                           txd,
    output logic                           rxd_out,
    output logic                           sclk_out,
    output logic                           ti,
    output logic                           busy,
    output logic                           fifo_empty,
    output logic                           fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           ovf
);

    localparam int unsigned TICK_W = $clog2(OSR);
    localparam int unsigned BIT_W  = 3;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OSR / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_e         r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_nxt;
    logic [TICK_W-1:0] r_tick_cnt, w_tick_nxt;
    tx_cfg_t           r_cfg, w_cfg_nxt;
    logic              r_par, w_par_nxt;
    logic              r_ti, r_ovf;
    logic              w_wr, w_load, w_frame_end;
    logic [DATA_W-1:0] w_fifo_dout;

    if (DATA_W < 8) begin : g_db_hi
        logic w_unused_db_hi;
        assign w_unused_db_hi = ^db_w[7:DATA_W];
    end

    assign w_wr = !wrn && (ab == TX_ADDR);

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr && !fifo_full),
        .pop   (w_load),
        .din   (db_w[DATA_W-1:0]),
        .dout  (w_fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_tick_cnt <= '0;
            r_cfg      <= '0;
            r_par      <= 1'b0;
            r_ti       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_cfg      <= w_cfg_nxt;
            r_par      <= w_par_nxt;
            r_ti       <= w_frame_end;
            r_ovf      <= w_wr && fifo_full;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit_cnt;
        w_tick_nxt  = r_tick_cnt;
        w_cfg_nxt   = r_cfg;
        w_par_nxt   = r_par;
        w_frame_end = 1'b0;
        w_load      = 1'b0;
        if (baud_tick) begin
            if (r_state == IDLE) begin
                w_load = !fifo_empty;
            end else if (r_tick_cnt != TICK_LAST) begin
                w_tick_nxt = r_tick_cnt + 1'b1;
            end else begin
                w_tick_nxt = '0;
                unique case (r_state)
                    START: w_state_nxt = DATA;
                    DATA: begin
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_nxt = '0;
                            if (r_cfg.mode == MODE_SYNC) begin
                                w_frame_end = 1'b1;
                            end else if (r_cfg.mode == MODE_ASYNC8) begin
                                w_state_nxt = STOP;
                            end else begin
                                w_state_nxt = NINTH;
                            end
                        end else begin
                            w_shreg_nxt = r_shreg >> 1;
                            w_bit_nxt   = r_bit_cnt + 1'b1;
                        end
                    end
                    NINTH: w_state_nxt = STOP;
                    STOP: begin
                        // bit_cnt doubles as the stop-bit counter.
                        if (r_cfg.stop2 && (r_bit_cnt == '0)) begin
                            w_bit_nxt = BIT_W'(1);
                        end else begin
                            w_frame_end = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (w_frame_end) begin
                    if (fifo_empty) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
        end
        if (w_load) begin
            w_shreg_nxt = w_fifo_dout;
            w_par_nxt   = ^w_fifo_dout;
            w_cfg_nxt   = '{mode: mode, par_en: par_en, par_odd: par_odd, tb8: tb8, stop2: stop2};
            w_bit_nxt   = '0;
            w_tick_nxt  = '0;
            w_state_nxt = (mode == MODE_SYNC) ? DATA : START;
        end
    end

    always_comb begin
        txd      = 1'b1;
        rxd_out  = 1'b1;
        sclk_out = 1'b1;
        unique case (r_state)
            START: txd = 1'b0;
            DATA: begin
                if (r_cfg.mode == MODE_SYNC) begin
                    rxd_out  = r_shreg[0];
                    sclk_out = (r_tick_cnt >= TICK_HALF);
                end else begin
                    txd = r_shreg[0];
                end
            end
            NINTH:   txd = r_cfg.par_en ? (r_par ^ r_cfg.par_odd) : r_cfg.tb8;
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign ti   = r_ti;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench: writes push expected frames, monitors decode txd / rxd_out+sclk_out and compare.
module tb_uart_tx_fifo_param;

    localparam int unsigned DW    = 7;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OSR   = 16;
    localparam int unsigned DIV   = 2;
    localparam int unsigned P     = OSR * DIV;
    localparam logic [7:0]  ADDR  = 8'h99;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst, wrn, par_en, par_odd, tb8, stop2, tick_en, baud_tick;
    logic [7:0] ab, db_w;
    logic [1:0] mode;
    logic       txd, rxd_out, sclk_out, ti, busy, fifo_empty, fifo_full, ovf;
    logic [2:0] fifo_level;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ti_cnt = 0;
    int ovf_cnt = 0;
    int exp_ti_total = 0;

    frame_t     exp_a_q[$];
    logic [7:0] exp_s_q[$];
    int         start_cyc_q[$];

    // async monitor state
    logic        a_active = 1'b0;
    logic        a_ti_wait = 1'b0;
    logic        a_unstable;
    logic [15:0] a_obs;
    int          a_pos = 0;
    int          a_bit;
    frame_t      a_cur;

    uart_tx_fifo_param #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .OSR        (OSR),
        .TX_ADDR    (ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ab         (ab),
        .wrn        (wrn),
        .db_w       (db_w),
        .baud_tick  (baud_tick),
        .mode       (mode),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .tb8        (tb8),
        .stop2      (stop2),
        .txd        (txd),
        .rxd_out    (rxd_out),
        .sclk_out   (sclk_out),
        .ti         (ti),
        .busy       (busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign baud_tick = tick_en && (cyc % DIV == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start, DW data bits LSB first, optional 9th bit, 1 or 2 stop bits.
    function automatic frame_t build(input logic [7:0] b);
        frame_t f;
        int ones = 0;
        f.bits = '0;
        f.n    = 1;
        for (int i = 0; i < DW; i++) begin
            f.bits[f.n] = b[i];
            ones += int'(b[i]);
            f.n++;
        end
        if (mode[1]) begin
            f.bits[f.n] = par_en ? 1'((ones + int'(par_odd)) % 2) : tb8;
            f.n++;
        end
        for (int i = 0; i < (stop2 ? 2 : 1); i++) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    task automatic set_cfg(input logic [1:0] m, input logic pe, po, t8, s2);
        mode = m; par_en = pe; par_odd = po; tb8 = t8; stop2 = s2;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        ab = ADDR; db_w = b; wrn = 1'b0;
        if (accept) begin
            if (mode == 2'b00) exp_s_q.push_back(b & 8'((1 << DW) - 1));
            else exp_a_q.push_back(build(b));
            exp_ti_total++;
        end
        @(posedge clk); #1;
        wrn = 1'b1; ab = 8'h00;
    endtask

    task automatic decoy_write();
        ab = ADDR ^ 8'(1 << $urandom_range(0, 7)); db_w = 8'($urandom); wrn = 1'b0;
        @(posedge clk); #1;
        wrn = 1'b1; ab = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(busy === 1'b0 && fifo_empty === 1'b1) && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_idle"}, 32'(busy === 1'b0 && fifo_empty === 1'b1), 1);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_queue_drained"}, exp_a_q.size() + exp_s_q.size(), 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (ti === 1'b1) ti_cnt++;
        if (ovf === 1'b1) ovf_cnt++;
    end

    // Async monitor: every clk of every bit must match the expected frame.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            a_active = 1'b0; a_ti_wait = 1'b0;
        end else begin
            if (a_ti_wait) begin
                chk("async_ti_at_frame_end", 32'(ti), 1);
                a_ti_wait = 1'b0;
            end
            if (!a_active && txd === 1'b0) begin
                start_cyc_q.push_back(cyc);
                chk("async_start_expected", 32'(exp_a_q.size() > 0), 1);
                if (exp_a_q.size() > 0) begin
                    a_cur = exp_a_q.pop_front();
                    a_active = 1'b1; a_pos = 0; a_obs = '0; a_unstable = 1'b0;
                end
            end
            if (a_active) begin
                a_bit = a_pos / P;
                if (txd !== a_cur.bits[a_bit]) a_unstable = 1'b1;
                if (a_pos % P == P / 2) a_obs[a_bit] = txd;
                a_pos++;
                if (a_pos == a_cur.n * P) begin
                    chk("async_frame_bits", 32'(a_obs), 32'(a_cur.bits));
                    chk("async_bit_hold", 32'(a_unstable), 0);
                    a_active = 1'b0; a_ti_wait = 1'b1;
                end
            end
        end
    end

    // Sync monitor: capture rxd_out on sclk_out rising edges.
    initial begin
        logic       s_prev = 1'b1;
        logic       s_wait_ti = 1'b0;
        logic [7:0] s_data = '0;
        int         s_cnt = 0;
        int         s_wait = 0;
        int         s_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_cnt = 0; s_wait_ti = 1'b0;
            end else begin
                if (s_wait_ti) begin
                    s_wait++;
                    if (ti === 1'b1) begin
                        chk("sync_ti_delay", s_wait, P / 2);
                        s_wait_ti = 1'b0;
                    end else if (s_wait > P) begin
                        chk("sync_ti_seen", 0, 1);
                        s_wait_ti = 1'b0;
                    end
                end
                if (s_prev === 1'b0 && sclk_out === 1'b1) begin
                    if (s_cnt == 0) s_data = '0;
                    else chk("sclk_period", cyc - s_last, P);
                    s_last = cyc;
                    s_data[s_cnt] = rxd_out;
                    s_cnt++;
                    if (s_cnt == DW) begin
                        chk("sync_frame_expected", 32'(exp_s_q.size() > 0), 1);
                        if (exp_s_q.size() > 0) chk("sync_data", s_data, exp_s_q.pop_front());
                        s_cnt = 0; s_wait_ti = 1'b1; s_wait = 0;
                    end
                end
            end
            s_prev = sclk_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ti_before;
        rst = 1'b1; wrn = 1'b1; ab = 8'h00; db_w = 8'h00; tick_en = 1'b1;
        set_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(txd), 1);
        chk("rst_rxd_out", 32'(rxd_out), 1);
        chk("rst_sclk_out", 32'(sclk_out), 1);
        chk("rst_ti", 32'(ti), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_fifo_empty", 32'(fifo_empty), 1);
        chk("rst_fifo_level", 32'(fifo_level), 0);
        rst = 1'b0;

        set_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0); write_byte(8'hA5, 1); wait_idle("async8");
        set_cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b0); write_byte(8'h07, 1); wait_idle("par_even");
        set_cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b0); write_byte(8'h07, 1); wait_idle("par_odd");
        set_cfg(2'b11, 1'b0, 1'b0, 1'b1, 1'b0); write_byte(8'h07, 1); wait_idle("tb8");
        set_cfg(2'b10, 1'b0, 1'b0, 1'b0, 1'b1); write_byte(8'hFF, 1); wait_idle("stop2");
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b1); write_byte(8'h3C, 1); wait_idle("sync");

        // Fill the FIFO with the tick held off, then let four frames run back to back.
        set_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_en = 1'b0;
        for (int i = 0; i < 5; i++) write_byte(8'(8'h31 + 8'(i * 17)), i < 4);
        chk("full_flag", 32'(fifo_full), 1);
        chk("full_level", 32'(fifo_level), DEPTH);
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_pulses", ovf_cnt, 1);
        start_cyc_q.delete();
        tick_en = 1'b1;
        wait_idle("burst");
        chk("burst_frames", start_cyc_q.size(), 4);
        for (int i = 1; i < 4 && i < start_cyc_q.size(); i++)
            chk("burst_no_gap", start_cyc_q[i] - start_cyc_q[i-1], (2 + DW) * P);
        chk("burst_level_end", 32'(fifo_level), 0);

        for (int k = 0; k < 18; k++) begin
            int nb;
            set_cfg(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom));
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1;
                if ($urandom_range(0, 3) == 0) decoy_write();
                n = 0;
                while (fifo_full === 1'b1 && n < 5000) begin
                    @(posedge clk); #1; n++;
                end
                write_byte(8'($urandom), 1);
            end
            // Config changes after the frame has started must not affect it.
            if (nb == 1 && $urandom_range(0, 1) == 1) begin
                n = 0;
                while (busy !== 1'b1 && n < 100) begin
                    @(posedge clk); #1; n++;
                end
                set_cfg(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom));
            end
            wait_idle("rand");
        end

        // Reset during data bit 3 with two bytes still queued.
        set_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) write_byte(8'(8'h5A + 8'(i)), 1);
        n = 0;
        while (!(a_active && a_pos >= 4 * P + 2) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("reached_data_bit3", 32'(a_active && a_pos >= 4 * P + 2), 1);
        ti_before = ti_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ti_total -= 1 + exp_a_q.size();
        exp_a_q.delete();
        chk("abort_txd", 32'(txd), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fifo_empty", 32'(fifo_empty), 1);
        chk("abort_fifo_level", 32'(fifo_level), 0);
        chk("abort_ti", 32'(ti), 0);
        repeat (3 * (3 + DW) * P) @(posedge clk);
        #1;
        chk("abort_no_ti", ti_cnt, ti_before);
        chk("abort_still_idle", 32'(busy), 0);

        chk("ti_total", ti_cnt, exp_ti_total);
        chk("ovf_total", ovf_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
